gesture_score_engine: RTL
=========================

Name: gesture_score_engine

Overview:
- Reader side of the per-class weight memories and the voxel-bin count memory.
- On `start`, sweeps every cell address once and drives one shared `cell_addr` to both memories.
- Multiply-accumulates `count × weight` per gesture class, then runs a sequential argmax over the classes.
- Publishes all class scores, the winning class and its score, with a one-cycle `score_valid` pulse; the result feeds the gesture output/UART stage.

Parameters:
- NUM_CELLS, 1024, cells swept per frame (bins × grid²).
- NUM_CLASSES, 4, gesture classes scored in parallel.
- WEIGHT_BITS, 8, signed weight width per class.
- COUNT_BITS, 8, unsigned voxel count width.
- ACC_BITS, 24, signed accumulator / score width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a scoring pass; sampled only in IDLE.
- busy  out  1  high from the start-accept edge until the return to IDLE.
- cell_addr  out  $clog2(NUM_CELLS)  registered address to the voxel memory and all weight memories.
- voxel_count  in  COUNT_BITS  unsigned count; valid one cycle after `cell_addr`.
- weight_in  in  NUM_CLASSES*WEIGHT_BITS  signed weights; class c occupies [c*WEIGHT_BITS +: WEIGHT_BITS]; valid one cycle after `cell_addr`.
- scores_out  out  NUM_CLASSES*ACC_BITS  signed final scores, packed the same way as `weight_in`.
- best_class  out  $clog2(NUM_CLASSES)  argmax class index.
- best_score  out  ACC_BITS  score of `best_class`.
- score_valid  out  1  one-cycle pulse when the result registers update.

Behaviour:
- Reset values: all outputs 0 (`busy`, `cell_addr`, `scores_out`, `best_class`, `best_score`, `score_valid`); accumulators 0; state IDLE.
- States: IDLE, SWEEP, ARGMAX, DONE.
- IDLE → SWEEP:
  - Transition on edge E0 where `start` = 1.
  - At E0: `busy` ← 1, `cell_addr` ← 0, accumulators cleared, data-valid pipe flag ← 1.
- SWEEP:
  - Edges E1..E(N-1) increment `cell_addr`, reaching N-1 at E(N-1), where N = NUM_CELLS.
  - Edges E1..EN accumulate the data for address k-1.
  - Accumulate rule: per class, acc += sign-extended(zero-extended `voxel_count` × signed weight).
  - Product width is COUNT_BITS+1+WEIGHT_BITS signed, extended to ACC_BITS.
  - Default accumulation is two's-complement wrap.
  - At EN: last accumulate, `cell_addr` ← 0, state ← ARGMAX.
- ARGMAX:
  - Edges E(N+1)..E(N+C) scan classes 0..C-1, C = NUM_CLASSES.
  - Candidate replaces the running best only on a strictly greater signed score, so ties resolve to the lowest index.
  - At E(N+C): `scores_out`, `best_class`, `best_score` load from the accumulators/argmax; `score_valid` ← 1; state ← DONE.
- DONE: at the next edge, `score_valid` ← 0, `busy` ← 0, state ← IDLE. `start` is ignored in DONE.
- Latency: `score_valid` is high in the cycle following E(N+C), i.e. N+C cycles after the accept edge (1028 for defaults).
- Output results hold their values until the next `score_valid`; they are not cleared at start.
- `start` while `busy`: ignored, with no restart and no effect on timing.
- `rst` mid-pass: takes priority over everything. Return to IDLE with all reset values, including result registers; no `score_valid` for the aborted pass.
- Back-to-back passes: `start` high in the first IDLE cycle after DONE is accepted. Minimum period is N+C+2 cycles.

Optional Feature:
- SCORE_SAT_EN defined:
  - Each per-class accumulate saturates to [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
  - Once saturated, a value stays clamped until a subsequent opposite-signed add brings it back in range. The sum is computed one bit wider, then clamped.
- Undefined: two's-complement wrap at ACC_BITS.

Test Plan:
- Zero frame: all `voxel_count` = 0, arbitrary weights, start at cycle 0 → `score_valid` exactly 1028 cycles after accept; all scores 0, `best_class` 0, `best_score` 0.
- Single event: count = 3 at address 5 only, class c weight = c-1 at every address → `scores_out` = {-3, 0, 3, 6}, `best_class` 3, `best_score` 6. Verify `cell_addr` sequence 0..1023 with no gaps.
- Tie: count = 1 and all weights = 2 everywhere → every score = 2048, `best_class` 0.
- Start-while-busy: extra `start` pulses at cycles 100 and 1028 → single pass, `score_valid` only at 1028. Back-to-back start on cycle 1029 → second valid at 2058.
- Reset mid-sweep: `rst` at sweep cycle 500 after a completed pass → next cycle `busy` 0, `cell_addr` 0, results 0, no `score_valid`. A fresh pass then completes normally.
- Overflow, ACC_BITS = 16, count 255, class 0 weight 127 everywhere → with SCORE_SAT_EN: score 32767; without: score 1024 (33162240 mod 65536).

Source files
------------

// File: rtl/gesture_score_if.sv
// gesture_score_if: start/score handshake, shared cell address, memory read data and result bus of the scoring engine.
// Modports: slave (engine side) takes start, voxel_count and weight_in, and drives busy, cell_addr and the results.
// master (requester/memory side) is the mirror image.
interface gesture_score_if #(
    parameter int NUM_CELLS   = 1024,
    parameter int NUM_CLASSES = 4,
    parameter int WEIGHT_BITS = 8,
    parameter int COUNT_BITS  = 8,
    parameter int ACC_BITS    = 24
) ();
    logic                              start;
    logic                              busy;
    logic [$clog2(NUM_CELLS)-1:0]      cell_addr;
    logic [COUNT_BITS-1:0]             voxel_count;
    logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in;
    logic [NUM_CLASSES*ACC_BITS-1:0]   scores_out;
    logic [$clog2(NUM_CLASSES)-1:0]    best_class;
    logic [ACC_BITS-1:0]               best_score;
    logic                              score_valid;

    modport slave (
        input  start, voxel_count, weight_in,
        output busy, cell_addr, scores_out, best_class, best_score, score_valid
    );
    modport master (
        output start, voxel_count, weight_in,
        input  busy, cell_addr, scores_out, best_class, best_score, score_valid
    );
endinterface

// File: rtl/gesture_score_engine.sv
// gesture_score_engine: sweeps all cells, accumulates count x weight per class, then picks the argmax class.
// Ports: clk, rst (sync, active-high), bus (gesture_score_if.slave: start, busy, cell_addr, voxel_count,
// weight_in, scores_out, best_class, best_score, score_valid).
// Optional macro SCORE_SAT_EN: saturating per-class accumulation instead of two's-complement wrap.
module gesture_score_engine #(
    parameter int NUM_CELLS   = 1024,
    parameter int NUM_CLASSES = 4,
    parameter int WEIGHT_BITS = 8,
    parameter int COUNT_BITS  = 8,
    parameter int ACC_BITS    = 24
) (
    input  logic             clk,
    input  logic             rst,
    gesture_score_if.slave   bus
);
    localparam int AW = $clog2(NUM_CELLS);
    localparam int CW = $clog2(NUM_CLASSES);
    localparam int PW = COUNT_BITS + 1 + WEIGHT_BITS;

    typedef enum logic [1:0] {IDLE, SWEEP, ARGMAX, DONE} state_t;

    state_t                     state;
    logic signed [ACC_BITS-1:0] acc [NUM_CLASSES];
    logic signed [ACC_BITS-1:0] nxt [NUM_CLASSES];
    logic [CW-1:0]              idx;
    logic [CW-1:0]              run_cls;
    logic signed [ACC_BITS-1:0] run_best;
    logic signed [ACC_BITS-1:0] cand;
    logic signed [ACC_BITS-1:0] nb;
    logic [CW-1:0]              nc;
    logic                       take;
    logic [NUM_CLASSES*ACC_BITS-1:0] packed_acc;

    genvar c;
    for (c = 0; c < NUM_CLASSES; c++) begin : g_mac
        logic signed [PW-1:0] prod;
        // count is unsigned, so a zero bit is prepended before the signed multiply
        assign prod = $signed({1'b0, bus.voxel_count}) * $signed(bus.weight_in[c*WEIGHT_BITS +: WEIGHT_BITS]);
`ifdef SCORE_SAT_EN
        localparam int SW = (PW > ACC_BITS ? PW : ACC_BITS) + 1;
        localparam logic signed [ACC_BITS-1:0] AMAX = {1'b0, {(ACC_BITS-1){1'b1}}};
        localparam logic signed [ACC_BITS-1:0] AMIN = {1'b1, {(ACC_BITS-1){1'b0}}};
        logic signed [SW-1:0] sum;
        assign sum = SW'(acc[c]) + SW'(prod);
        assign nxt[c] = sum > SW'(AMAX) ? AMAX : sum < SW'(AMIN) ? AMIN : sum[ACC_BITS-1:0];
`else
        assign nxt[c] = acc[c] + ACC_BITS'(prod);
`endif
    end

    // class 0 always seeds the running best; later classes win only when strictly greater
    always_comb begin
        cand = acc[idx];
        take = idx == '0 || cand > run_best;
        nb   = take ? cand : run_best;
        nc   = take ? idx : run_cls;
    end

    always_comb begin
        packed_acc = '0;
        for (int i = 0; i < NUM_CLASSES; i++) packed_acc[i*ACC_BITS +: ACC_BITS] = acc[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            run_cls         <= '0;
            run_best        <= '0;
            bus.busy        <= 1'b0;
            bus.cell_addr   <= '0;
            bus.scores_out  <= '0;
            bus.best_class  <= '0;
            bus.best_score  <= '0;
            bus.score_valid <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state         <= SWEEP;
                    bus.busy      <= 1'b1;
                    bus.cell_addr <= '0;
                    for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= '0;
                end
                SWEEP: begin
                    // read data arriving now belongs to the address currently driven
                    for (int i = 0; i < NUM_CLASSES; i++) acc[i] <= nxt[i];
                    if (bus.cell_addr == AW'(NUM_CELLS - 1)) begin
                        bus.cell_addr <= '0;
                        idx           <= '0;
                        state         <= ARGMAX;
                    end else begin
                        bus.cell_addr <= bus.cell_addr + 1'b1;
                    end
                end
                ARGMAX: begin
                    run_best <= nb;
                    run_cls  <= nc;
                    idx      <= idx + 1'b1;
                    if (idx == CW'(NUM_CLASSES - 1)) begin
                        bus.scores_out  <= packed_acc;
                        bus.best_class  <= nc;
                        bus.best_score  <= nb;
                        bus.score_valid <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    bus.score_valid <= 1'b0;
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
